// File: rtl/instruction_sequencer.sv
// Stores 32-bit program words from a host and replays them to the cpu, one per clock, for a given number of passes.
// Define SEQUENCER_TENSOR_WAIT_EN to insert NOP padding after each tensor-core operate (opcode 8'h05).
module instruction_sequencer #(
    parameter int DEPTH              = 64,
    parameter int TENSOR_WAIT_CYCLES = 4
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   load_valid_in,
    input  logic [31:0]            load_data_in,
    output logic                   load_ready_out,
    input  logic                   clear_in,
    input  logic                   start_in,
    input  logic                   halt_in,
    input  logic [7:0]             loop_count_in,
    output logic [31:0]            current_instruction_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [$clog2(DEPTH):0] program_length_out
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [31:0]   NOP       = 32'h0000_0008;
    localparam logic [7:0]    OP_TENSOR = 8'h05;

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef SEQUENCER_TENSOR_WAIT_EN
        S_WAIT,
`endif
        S_RUN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt, w_pc_adv;
    logic [7:0]    r_passes, w_passes_nxt, w_passes_adv;
    logic [AW:0]   r_len, w_len_nxt;
    logic [31:0]   r_instr, w_instr_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_done_pend, w_done_pend_nxt;
    logic [31:0]   r_mem [DEPTH];

    logic [31:0]   w_word;
    logic          w_end, w_fin, w_load_acc, w_start_acc;

`ifdef SEQUENCER_TENSOR_WAIT_EN
    logic [7:0]    r_wait, w_wait_nxt;
    logic          r_fin_after, w_fin_after_nxt;
`else
    logic [7:0]    w_unused_wait;
    assign w_unused_wait = 8'(TENSOR_WAIT_CYCLES);
`endif

    assign load_ready_out          = (r_state == S_IDLE) && (r_len < DEPTH_L);
    assign current_instruction_out = r_instr;
    assign busy_out                = r_busy;
    assign done_out                = r_done;
    assign program_length_out      = r_len;

    assign w_load_acc   = load_valid_in && load_ready_out && !clear_in;
    assign w_start_acc  = (r_state == S_IDLE) && start_in && !halt_in && !clear_in
                          && !(load_valid_in && load_ready_out);
    assign w_word       = r_mem[r_pc];
    assign w_end        = ({1'b0, r_pc} == (r_len - 1'b1));
    assign w_fin        = w_end && (r_passes == 8'd0);
    assign w_pc_adv     = w_end ? '0 : r_pc + 1'b1;
    assign w_passes_adv = (w_end && r_passes != 8'd0) ? r_passes - 8'd1 : r_passes;

    // Output registers lag the state by one cycle: RUN/WAIT decide what appears after the next edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_passes_nxt    = r_passes;
        w_len_nxt       = r_len;
        w_instr_nxt     = NOP;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_done_pend_nxt = 1'b0;
`ifdef SEQUENCER_TENSOR_WAIT_EN
        w_wait_nxt      = r_wait;
        w_fin_after_nxt = r_fin_after;
`endif
        case (r_state)
            S_IDLE: begin
                w_done_nxt = r_done_pend;
                if (clear_in) begin
                    w_len_nxt = '0;
                end else if (w_load_acc) begin
                    w_len_nxt = r_len + 1'b1;
                end
                if (w_start_acc) begin
                    if (r_len == '0) begin
                        w_done_pend_nxt = 1'b1;
                    end else begin
                        w_pc_nxt     = '0;
                        w_passes_nxt = loop_count_in;
                        w_state_nxt  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (halt_in) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_instr_nxt  = w_word;
                    w_busy_nxt   = 1'b1;
                    w_pc_nxt     = w_pc_adv;
                    w_passes_nxt = w_passes_adv;
`ifdef SEQUENCER_TENSOR_WAIT_EN
                    if (w_word[7:0] == OP_TENSOR) begin
                        w_state_nxt     = S_WAIT;
                        w_wait_nxt      = 8'(TENSOR_WAIT_CYCLES);
                        w_fin_after_nxt = w_fin;
                    end else
`endif
                    if (w_fin) begin
                        w_state_nxt     = S_IDLE;
                        w_done_pend_nxt = 1'b1;
                    end
                end
            end
`ifdef SEQUENCER_TENSOR_WAIT_EN
            S_WAIT: begin
                if (halt_in) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_wait_nxt = r_wait - 8'd1;
                    // pc was already advanced when the operate issued; only the exit path remains.
                    if (r_wait == 8'd1) begin
                        if (r_fin_after) begin
                            w_state_nxt     = S_IDLE;
                            w_done_pend_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_passes    <= '0;
            r_len       <= '0;
            r_instr     <= NOP;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
`ifdef SEQUENCER_TENSOR_WAIT_EN
            r_wait      <= '0;
            r_fin_after <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_passes    <= w_passes_nxt;
            r_len       <= w_len_nxt;
            r_instr     <= w_instr_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_done_pend <= w_done_pend_nxt;
`ifdef SEQUENCER_TENSOR_WAIT_EN
            r_wait      <= w_wait_nxt;
            r_fin_after <= w_fin_after_nxt;
`endif
        end
    end

    always_ff @(posedge clock_in) begin
        if (w_load_acc) begin
            r_mem[r_len[AW-1:0]] <= load_data_in;
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed plus randomized playback checks for instruction_sequencer against a queue-based program model.
module tb_instruction_sequencer;
    localparam int          DEPTH = 64;
    localparam int          TWC   = 4;
    localparam logic [31:0] NOP   = 32'h0000_0008;
`ifdef SEQUENCER_TENSOR_WAIT_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  loop_count = '0;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic [6:0]  plen;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] prog[$];
    logic [31:0] exp_q[$];

    instruction_sequencer #(.DEPTH(DEPTH), .TENSOR_WAIT_CYCLES(TWC)) dut (
        .clock_in               (clk),
        .reset_n_in             (rst_n),
        .load_valid_in          (load_valid),
        .load_data_in           (load_data),
        .load_ready_out         (load_ready),
        .clear_in               (clear),
        .start_in               (start),
        .halt_in                (halt),
        .loop_count_in          (loop_count),
        .current_instruction_out(instr),
        .busy_out               (busy),
        .done_out               (done),
        .program_length_out     (plen)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[7:0] = 8'h05;
        return w;
    endfunction

    // Expected issue stream: each pass replays the program, operates followed by TWC NOPs when padding is on.
    task automatic build_exp(input int loops);
        exp_q.delete();
        for (int p = 0; p <= loops; p++) begin
            foreach (prog[i]) begin
                exp_q.push_back(prog[i]);
                if (PAD_EN && prog[i][7:0] == 8'h05)
                    for (int k = 0; k < TWC; k++) exp_q.push_back(NOP);
            end
        end
    endtask

    task automatic load_word(input logic [31:0] w);
        chk("load_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        prog.push_back(w);
    endtask

    task automatic clear_prog();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        prog.delete();
        chk("clear_len", plen, 0);
    endtask

    task automatic run_prog(input int loops, input string tag);
        build_exp(loops);
        loop_count = 8'(loops);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_at_start"}, busy, 0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk($sformatf("%s/instr[%0d]", tag, i), instr, exp_q[i]);
            chk($sformatf("%s/busy[%0d]", tag, i), busy, 1);
            chk($sformatf("%s/done[%0d]", tag, i), done, 0);
        end
        @(negedge clk);
        chk({tag, "/end_instr"}, instr, NOP);
        chk({tag, "/end_done"}, done, 1);
        chk({tag, "/end_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "/done_pulse"}, done, 0);
        chk({tag, "/len_kept"}, plen, prog.size());
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_instr", instr, NOP);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_len", plen, 0);
        chk("rst_ready", load_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_instr", instr, NOP);

        load_word(32'h0201_0000);
        load_word(32'h0302_0109);
        load_word(32'h0000_0008);
        chk("basic_len", plen, 3);
        run_prog(0, "basic");
        run_prog(2, "repeat");

        clear_prog();
        load_word(32'h0000_0005);
        load_word(32'h0000_0000);
        run_prog(0, "operate");

        for (int it = 0; it < 8; it++) begin
            int n;
            clear_prog();
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) load_word(rand_word());
            chk("rand_len", plen, n);
            run_prog($urandom_range(0, 3), $sformatf("rand%0d", it));
        end

        clear_prog();
        for (int j = 0; j < DEPTH; j++) load_word(rand_word());
        chk("full_len", plen, DEPTH);
        chk("full_ready", load_ready, 0);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        load_valid = 1'b0;
        chk("full_len_after_extra", plen, DEPTH);
        run_prog(0, "full");

        clear_prog();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done_early", done, 0);
        chk("empty_busy0", busy, 0);
        @(negedge clk);
        chk("empty_done", done, 1);
        chk("empty_busy1", busy, 0);
        chk("empty_instr", instr, NOP);
        @(negedge clk);
        chk("empty_done_pulse", done, 0);

        load_valid = 1'b1;
        load_data  = 32'h0000_1101;
        start      = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b0;
        prog.push_back(32'h0000_1101);
        chk("loadstart_len", plen, 1);
        chk("loadstart_busy0", busy, 0);
        @(negedge clk);
        chk("loadstart_busy1", busy, 0);
        chk("loadstart_instr", instr, NOP);

        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h0000_2201;
        @(negedge clk);
        clear      = 1'b0;
        load_valid = 1'b0;
        prog.delete();
        chk("clearload_len", plen, 0);

        for (int j = 0; j < 5; j++) load_word({16'h00A0, 8'(j), 8'h01});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("halt_w0", instr, prog[0]);
        @(negedge clk);
        chk("halt_w1", instr, prog[1]);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_instr", instr, NOP);
        chk("halt_busy", busy, 0);
        chk("halt_done", done, 0);
        chk("halt_len", plen, 5);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("halt_nodone", done, 0);
        end
        chk("halt_ready", load_ready, 1);
        run_prog(0, "after_halt");

        clear_prog();
        load_word(32'h0000_0005);
        load_word(32'h0000_0001);
        build_exp(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_w0", instr, exp_q[0]);
        @(negedge clk);
        chk("mid_w1", instr, exp_q[1]);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_instr", instr, NOP);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_len", plen, 0);
        chk("midrst_ready", load_ready, 1);
        prog.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_len", plen, 0);
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

- Stores a program of 32-bit instruction words and issues it, one word per clock, onto the `cpu` instruction bus (`current_instruction`).
- Sits upstream of `cpu` as the producer end of the instruction interface.
- A host loads words through a valid/ready port, then starts playback with an optional repeat count.
- Inserts NOP padding after tensor-core operate instructions so the tensor core can finish before the next instruction.

## Interface
- `DEPTH`, 64, program memory depth in words (power of two, ≥2).
- `TENSOR_WAIT_CYCLES`, 4, NOP words inserted after each `TENSOR_CORE_OPERATE` (opcode 8'h05), 1..255.
- `clock_in`  in  1  single clock; all state updates on its rising edge.
- `reset_n_in`  in  1  asynchronous, active-low reset.
- `load_valid_in`  in  1  host offers a program word.
- `load_data_in`  in  32  program word; bits [7:0] are the opcode.
- `load_ready_out`  out  1  word accepted on `load_valid_in && load_ready_out`.
- `clear_in`  in  1  empties program memory (length → 0); honoured only in IDLE.
- `start_in`  in  1  begin playback; honoured only in IDLE.
- `halt_in`  in  1  abort playback.
- `loop_count_in`  in  8  extra passes; total passes = value + 1; sampled on accepted start.
- `current_instruction_out`  out  32  registered instruction word to `cpu`.
- `busy_out`  out  1  high in RUN or WAIT.
- `done_out`  out  1  one-cycle pulse on normal completion.
- `program_length_out`  out  $clog2(DEPTH)+1  number of stored words.

## Operation
- NOP word is 32'h0000_0008.
- States: IDLE, RUN, WAIT.
- IDLE:
  - `current_instruction_out` = NOP.
  - `load_ready_out` = (length < DEPTH).
  - An accepted load writes `mem[length]` and increments length.
  - `clear_in` sets length to 0.
- Start in IDLE:
  - length == 0: pulse `done_out` next cycle, stay IDLE.
  - Otherwise: pc ← 0, passes_left ← `loop_count_in`, → RUN.
- RUN: each cycle, output ← `mem[pc]`.
  - The issued word's opcode is 8'h05 and the macro is enabled: wait_cnt ← `TENSOR_WAIT_CYCLES`, → WAIT.
  - End of pass (pc == length−1) with passes_left > 0: pc ← 0, passes_left decrements.
  - End of pass with passes_left == 0: next cycle output NOP, `done_out` pulses, → IDLE.
  - Otherwise pc increments.
- WAIT:
  - Output NOP each cycle; wait_cnt decrements.
  - At 0, resume RUN at the next pc, applying the same end-of-pass rules.
- Stored words, including RESET (8'h0D), are passed through unmodified.
- `halt_in` in RUN/WAIT: next cycle output NOP, → IDLE, no `done_out`, program memory kept.
- Same-cycle priority:
  - halt > start.
  - Load beats start: start is ignored in any cycle with an accepted load.
  - clear beats load.
  - Start is ignored while busy.

## Timing
- Reset values:
  - `current_instruction_out` = NOP.
  - `busy_out`, `done_out` = 0.
  - `program_length_out` = 0.
  - `load_ready_out` = 1.
  - FSM in IDLE, pc = 0.
- Reset asserted mid-run: returns to IDLE at once; program length is lost.
- Latency:
  - Start sampled at edge N → `mem[0]` valid after edge N+1; `busy_out` high from edge N+1.
  - A program of L words with P passes (no operates) occupies L·P cycles.
  - `done_out` pulses in the cycle after the last word, with `busy_out` low.
- Each operate adds exactly `TENSOR_WAIT_CYCLES` NOP cycles.
- Loads have single-cycle acceptance; `load_ready_out` is combinational from state and length.

## Configuration
- `SEQUENCER_TENSOR_WAIT_EN` defined: WAIT state and NOP padding are present as described.
- Undefined: WAIT state is removed, operate words issue back-to-back like any other word, and `TENSOR_WAIT_CYCLES` is unused.

## Test plan
- Basic playback: load 32'h0201_0000, 32'h0302_0109, 32'h0000_0008, then start with loop 0 → the three words appear on cycles 1–3, NOP on cycle 4 with `done_out`=1, `busy_out`=0.
- Repeat count: same program, loop_count 2 → 9 words in order, then one `done_out` pulse.
- Operate padding (macro on, wait 4): program {32'h0000_0005, 32'h0000_0000} → 05, NOP×4, 00, done. Macro off → 05, 00, done.
- Full/empty:
  - DEPTH loads → `load_ready_out` low; extra valid is not written; length = DEPTH.
  - `clear_in` → length 0; then start → `done_out` one cycle later, no instructions issued.
- Halt: halt at the 2nd word of a 5-word program → NOP next cycle, IDLE, no `done_out`, length still 5.
- Reset mid-run: deassert `reset_n_in` during WAIT → all outputs at reset values immediately, length 0.
